surf_lbus_initiator: RTL and testbench
======================================

// Module: surf_lbus_initiator
// PURPOSE
//  Local-bus initiator for the SURF register/HK/LAB target (nADS/WnR/LA/LD/nCS2/nCS3/nRD/nREADY).
//  Turns a simple request (space, address, beat count, write data) into one single-beat
//  address cycle per word, because the target does not burst. Used in the bench-side
//  controller and in the hang-test harness to read/write SURF registers, HK words and LAB data.
// PARAMETERS
//  TIMEOUT_CYCLES  255  WAIT cycles allowed per beat before the transfer aborts with err
//  GAP_CYCLES      2    idle cycles between beats (covers the target's LD output-enable lag)
// PORTS
//  clk_i        in   1   bus clock, same clock as the target; all logic on posedge
//  nrst_i       in   1   asynchronous, active-low reset
//  req_i        in   1   request strobe; sampled only in IDLE
//  req_wr_i     in   1   1=write, 0=read
//  req_space_i  in   2   0=REG (no CS), 1=HK (nCS2), 2=LAB (nCS3), 3=reserved (errors immediately)
//  req_addr_i   in   6   LA[7:2] word address; held for every beat
//  req_len_i    in   8   beats-1 (0 -> 1 beat, 255 -> 256 beats)
//  req_ack_o    out  1   1-cycle pulse when a request is accepted
//  wdat_i       in   32  write word for the current beat
//  wdat_ack_o   out  1   1-cycle pulse when wdat_i has been consumed; next word must be valid next cycle
//  rdat_o       out  32  read word, valid with rdat_valid_o
//  rdat_valid_o out  1   1-cycle pulse per read beat
//  busy_o       out  1   high from accept to done
//  done_o       out  1   1-cycle pulse at end of transfer
//  err_o        out  1   sticky until next accept; timeout or reserved space
//  nADS_o       out  1   address strobe, low one cycle per beat
//  WnR_o        out  1   1=write; idles at 1 so the target keeps LD tristated
//  LA_o         out  6   word address
//  LD           inout 32 data; driven only during write ADDR/WAIT
//  nCS2_o       out  1   HK select
//  nCS3_o       out  1   LAB select
//  nRD_o        out  1   low during read WAIT
//  nREADY_i     in   1   target ready, active low, sampled on posedge
//  nBTERM_i     in   1   monitored only; tied high by target
// BEHAVIOUR
//  Reset (async, nrst_i=0): state IDLE; nADS_o=1, WnR_o=1, nCS2_o=1, nCS3_o=1, nRD_o=1,
//   LA_o=0, LD released, busy_o=0, req_ack_o=0, wdat_ack_o=0, rdat_valid_o=0, done_o=0,
//   err_o=0, rdat_o=0. Reset mid-transfer releases LD and strobes immediately, with no done_o.
//  All bus outputs and LD enable are registered; no combinational path from inputs to pins.
//  FSM: IDLE -> ADDR -> WAIT -> GAP -> (ADDR | DONE) -> IDLE; WAIT -> ABORT -> DONE on timeout.
//  IDLE: req_i=1 -> latch wr/space/addr/len, req_ack_o pulse, busy_o=1, go to ADDR next cycle.
//   Space 3 -> err_o=1, straight to DONE, no bus activity.
//  ADDR (1 cycle): nADS_o=0, LA_o=addr, CS per space, WnR_o=wr; write: drive LD=wdat_i.
//  WAIT: nADS_o=1; CS, LA and WnR held; read: nRD_o=0, WnR_o=0; write: LD held.
//   nREADY_i=0 sampled -> read: rdat_o<=LD, rdat_valid_o pulse; write: wdat_ack_o pulse; -> GAP.
//   Timeout counter clears in ADDR; count reaching TIMEOUT_CYCLES with nREADY_i high -> ABORT.
//  GAP: all strobes inactive, WnR_o=1, LD released for GAP_CYCLES; beats remaining -> ADDR, else DONE.
//  ABORT: same as GAP; then DONE with err_o=1; remaining beats are dropped.
//  DONE (1 cycle): done_o pulse, busy_o=0 on the next cycle; back to IDLE. Earliest next accept is cycle after DONE.
//  Beat counter is 9 bits and loads req_len_i+1. It decrements on each ready, and the transfer ends at 0 (no wrap).
//  Read latency per beat: ADDR + 1 cycle for LAB, +2 cycles for REG/HK (target pipeline); the bench must not rely on fixed latency.
//  req_i while busy_o=1 is ignored (no ack). nREADY_i low outside WAIT is ignored.
//  nBTERM_i low has no effect on sequencing.
// TESTING
//  1 REG read addr 0, len 0, target model -> one nADS low, rdat_o=0x53555246 ("SURF"), done_o, err_o=0.
//  2 REG write addr 7, wdat 0xDEADBEEF, then read addr 7 -> rdat 0xDEADBEEF; LD tristate outside write ADDR/WAIT.
//  3 HK read addr 0, len 3, hk_counter=0 -> 4 nADS pulses with nCS2_o low; rdat_valid_o 4 times; target counter ends at 4.
//  4 nREADY_i held high, TIMEOUT_CYCLES=16, len 2 -> abort after 16 WAIT cycles, err_o=1, no rdat_valid_o, done_o once.
//  5 Read immediately followed by write -> no cycle where both sides drive LD (bench contention check), write lands correctly.
//  6 nrst_i low during write WAIT -> same cycle LD=Z, nADS_o/nCS*/nRD_o=1, WnR_o=1; no done_o; next req accepted normally.

Source files
------------

// File: rtl/surf_lbus_initiator.sv
// Local-bus initiator for the SURF target: one single-beat address cycle per word.
// Every bus pin and the LD enable comes from a flop, so no input reaches a pin combinationally.
module surf_lbus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        req_i,
  input  logic        req_wr_i,
  input  logic [1:0]  req_space_i,
  input  logic [5:0]  req_addr_i,
  input  logic [7:0]  req_len_i,
  output logic        req_ack_o,
  input  logic [31:0] wdat_i,
  output logic        wdat_ack_o,
  output logic [31:0] rdat_o,
  output logic        rdat_valid_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        nADS_o,
  output logic        WnR_o,
  output logic [5:0]  LA_o,
  inout  wire  [31:0] LD,
  output logic        nCS2_o,
  output logic        nCS3_o,
  output logic        nRD_o,
  input  logic        nREADY_i,
  input  logic        nBTERM_i
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_GAP, S_ABORT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          wr_q, wr_d;
  logic [1:0]    space_q, space_d;
  logic [5:0]    la_q, la_d;
  logic [8:0]    beats_q, beats_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ld_oe_q, ld_oe_d;
  logic [31:0]   ld_out_q, ld_out_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          nads_q, nads_d, wnr_q, wnr_d, ncs2_q, ncs2_d, ncs3_q, ncs3_d, nrd_q, nrd_d;
  logic          req_ack_q, req_ack_d, wdat_ack_q, wdat_ack_d, rdat_valid_q, rdat_valid_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic          go_addr, go_gap, addr_wr;
  logic [1:0]    addr_sp;
  logic          unused_bterm;

  assign unused_bterm = nBTERM_i;

  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    space_d      = space_q;
    la_d         = la_q;
    beats_d      = beats_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    ld_oe_d      = ld_oe_q;
    ld_out_d     = ld_out_q;
    rdat_d       = rdat_q;
    nads_d       = nads_q;
    wnr_d        = wnr_q;
    ncs2_d       = ncs2_q;
    ncs3_d       = ncs3_q;
    nrd_d        = nrd_q;
    busy_d       = busy_q;
    err_d        = err_q;
    req_ack_d    = 1'b0;
    wdat_ack_d   = 1'b0;
    rdat_valid_d = 1'b0;
    done_d       = 1'b0;
    go_addr      = 1'b0;
    go_gap       = 1'b0;
    addr_wr      = wr_q;
    addr_sp      = space_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          req_ack_d = 1'b1;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          wr_d      = req_wr_i;
          space_d   = req_space_i;
          la_d      = req_addr_i;
          beats_d   = {1'b0, req_len_i} + 9'd1;
          if (req_space_i == 2'd3) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            go_addr = 1'b1;
            addr_wr = req_wr_i;
            addr_sp = req_space_i;
          end
        end
      end
      S_ADDR: begin
        state_d = S_WAIT;
        nads_d  = 1'b1;
        if (!wr_q) begin
          nrd_d = 1'b0;
          wnr_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (!nREADY_i) begin
          if (wr_q) begin
            wdat_ack_d = 1'b1;
          end else begin
            rdat_d       = LD;
            rdat_valid_d = 1'b1;
          end
          beats_d = beats_q - 9'd1;
          state_d = S_GAP;
          go_gap  = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_ABORT;
          go_gap  = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_GAP, S_ABORT: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          if (state_q == S_GAP && beats_q != 9'd0) begin
            go_addr = 1'b1;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Entering ADDR is shared by the accept path and the inter-beat path.
    if (go_addr) begin
      state_d  = S_ADDR;
      nads_d   = 1'b0;
      wnr_d    = addr_wr;
      ncs2_d   = (addr_sp != 2'd1);
      ncs3_d   = (addr_sp != 2'd2);
      ld_oe_d  = addr_wr;
      ld_out_d = wdat_i;
      tmo_d    = '0;
    end
    if (go_gap) begin
      nrd_d   = 1'b1;
      wnr_d   = 1'b1;
      ncs2_d  = 1'b1;
      ncs3_d  = 1'b1;
      ld_oe_d = 1'b0;
      gap_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= S_IDLE;
      wr_q         <= 1'b0;
      space_q      <= '0;
      la_q         <= '0;
      beats_q      <= '0;
      tmo_q        <= '0;
      gap_q        <= '0;
      ld_oe_q      <= 1'b0;
      ld_out_q     <= '0;
      rdat_q       <= '0;
      nads_q       <= 1'b1;
      wnr_q        <= 1'b1;
      ncs2_q       <= 1'b1;
      ncs3_q       <= 1'b1;
      nrd_q        <= 1'b1;
      req_ack_q    <= 1'b0;
      wdat_ack_q   <= 1'b0;
      rdat_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      space_q      <= space_d;
      la_q         <= la_d;
      beats_q      <= beats_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      ld_oe_q      <= ld_oe_d;
      ld_out_q     <= ld_out_d;
      rdat_q       <= rdat_d;
      nads_q       <= nads_d;
      wnr_q        <= wnr_d;
      ncs2_q       <= ncs2_d;
      ncs3_q       <= ncs3_d;
      nrd_q        <= nrd_d;
      req_ack_q    <= req_ack_d;
      wdat_ack_q   <= wdat_ack_d;
      rdat_valid_q <= rdat_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign LD           = ld_oe_q ? ld_out_q : 'z;
  assign req_ack_o    = req_ack_q;
  assign wdat_ack_o   = wdat_ack_q;
  assign rdat_o       = rdat_q;
  assign rdat_valid_o = rdat_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign nADS_o       = nads_q;
  assign WnR_o        = wnr_q;
  assign LA_o         = la_q;
  assign nCS2_o       = ncs2_q;
  assign nCS3_o       = ncs3_q;
  assign nRD_o        = nrd_q;

endmodule

// File: tb/tb_surf_lbus_initiator.sv
// Bench for surf_lbus_initiator: behavioural SURF target plus directed transfers.
module tb_surf_lbus_initiator;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, req_wr = 1'b0;
  logic [1:0]  req_space = '0;
  logic [5:0]  req_addr = '0;
  logic [7:0]  req_len = '0;
  logic [31:0] wdat = '0;
  logic        req_ack, wdat_ack, rdat_valid, busy, done, err;
  logic        nads, wnr, ncs2, ncs3, nrd;
  logic        nready, nbterm = 1'b1;
  logic [31:0] rdat;
  logic [5:0]  la;
  wire  [31:0] ld_bus;
  logic        tgt_oe;
  logic [31:0] tgt_d;

  assign ld_bus = tgt_oe ? tgt_d : 'z;

  surf_lbus_initiator #(.TIMEOUT_CYCLES(16), .GAP_CYCLES(2)) dut (
    .clk_i(clk), .nrst_i(nrst), .req_i(req), .req_wr_i(req_wr), .req_space_i(req_space),
    .req_addr_i(req_addr), .req_len_i(req_len), .req_ack_o(req_ack), .wdat_i(wdat),
    .wdat_ack_o(wdat_ack), .rdat_o(rdat), .rdat_valid_o(rdat_valid), .busy_o(busy),
    .done_o(done), .err_o(err), .nADS_o(nads), .WnR_o(wnr), .LA_o(la), .LD(ld_bus),
    .nCS2_o(ncs2), .nCS3_o(ncs3), .nRD_o(nrd), .nREADY_i(nready), .nBTERM_i(nbterm)
  );

  // Target model: LAB answers one cycle after ADDR, REG/HK two cycles after.
  logic [1:0]  t_st;
  logic        t_wr;
  logic [1:0]  t_sp;
  logic [5:0]  t_a;
  logic        stall = 1'b0;
  logic [31:0] reg_mem [64];
  logic [31:0] lab_mem [64];
  logic [31:0] hk_cnt = '0;

  function automatic logic [31:0] rd_word(input logic [1:0] sp, input logic [5:0] a);
    if (sp == 2'd2) return lab_mem[a];
    if (sp == 2'd1) return hk_cnt;
    if (a == 6'd0) return 32'h5355_5246;
    return reg_mem[a];
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      t_st   <= 2'd0;
      nready <= 1'b1;
      tgt_oe <= 1'b0;
      tgt_d  <= '0;
    end else begin
      case (t_st)
        2'd0: if (!nads) begin
          t_wr <= wnr;
          t_sp <= !ncs3 ? 2'd2 : (!ncs2 ? 2'd1 : 2'd0);
          t_a  <= la;
          if (!ncs3 && !stall) begin
            nready <= 1'b0;
            if (!wnr) begin
              tgt_oe <= 1'b1;
              tgt_d  <= lab_mem[la];
            end
            t_st <= 2'd2;
          end else begin
            t_st <= 2'd1;
          end
        end
        2'd1: if (!stall) begin
          nready <= 1'b0;
          if (!t_wr) begin
            tgt_oe <= 1'b1;
            tgt_d  <= rd_word(t_sp, t_a);
          end
          t_st <= 2'd2;
        end
        default: begin
          nready <= 1'b1;
          tgt_oe <= 1'b0;
          t_st   <= 2'd0;
          if (t_wr) begin
            if (t_sp == 2'd0) reg_mem[t_a] <= ld_bus;
            if (t_sp == 2'd2) lab_mem[t_a] <= ld_bus;
          end else if (t_sp == 2'd1) begin
            hk_cnt <= hk_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  // Free-running event counters; tests work on deltas from a snapshot.
  int unsigned n_ads = 0, n_cs2 = 0, n_rv = 0, n_done = 0, n_ack = 0, n_wack = 0, n_nrd = 0;
  int unsigned n_cont = 0, n_bad = 0;
  logic [31:0] last_rd = '0, rd_sum = '0;

  always @(negedge clk) begin
    if (!nads) n_ads <= n_ads + 1;
    if (!nads && !ncs2) n_cs2 <= n_cs2 + 1;
    if (rdat_valid) begin
      n_rv    <= n_rv + 1;
      last_rd <= rdat;
      rd_sum  <= rd_sum + rdat;
    end
    if (done) n_done <= n_done + 1;
    if (req_ack) n_ack <= n_ack + 1;
    if (wdat_ack) n_wack <= n_wack + 1;
    if (!nrd) n_nrd <= n_nrd + 1;
    if (tgt_oe && dut.ld_oe_q) n_cont <= n_cont + 1;
    if (dut.ld_oe_q && !((!nads && wnr) || (t_st != 2'd0 && t_wr))) n_bad <= n_bad + 1;
  end

  int unsigned n_vec = 0, n_miss = 0;
  int unsigned b_ads, b_cs2, b_rv, b_done, b_ack, b_wack, b_nrd;
  logic [31:0] b_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_ads = n_ads; b_cs2 = n_cs2; b_rv = n_rv; b_done = n_done;
    b_ack = n_ack; b_wack = n_wack; b_nrd = n_nrd; b_sum = rd_sum;
  endtask

  task automatic xfer(input logic w, input logic [1:0] sp, input logic [5:0] a,
                      input logic [7:0] len, input logic [31:0] wd, input logic hold);
    logic got_ack = 1'b0;
    logic fin = 1'b0;
    req_wr = w; req_space = sp; req_addr = a; req_len = len; wdat = wd; req = 1'b1;
    for (int i = 0; i < 2000 && !fin; i++) begin
      @(negedge clk);
      if (req_ack) got_ack = 1'b1;
      if (done) fin = 1'b1;
      if (fin || (!hold && got_ack)) req = 1'b0;
    end
    req = 1'b0;
    if (!fin) check("done_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic seen;
    @(negedge clk);
    check("rst_nads", nads, 1);  check("rst_wnr", wnr, 1);    check("rst_ncs2", ncs2, 1);
    check("rst_ncs3", ncs3, 1);  check("rst_nrd", nrd, 1);    check("rst_la", la, 0);
    check("rst_busy", busy, 0);  check("rst_done", done, 0);  check("rst_err", err, 0);
    check("rst_rdat", rdat, 0);  check("rst_ack", req_ack, 0); check("rst_rv", rdat_valid, 0);
    check("rst_wack", wdat_ack, 0); check("rst_ld_oe", dut.ld_oe_q, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    snap(); xfer(1'b0, 2'd0, 6'd0, 8'd0, '0, 1'b0);
    check("t1_ads", n_ads - b_ads, 1);   check("t1_rv", n_rv - b_rv, 1);
    check("t1_rdat", last_rd, 32'h5355_5246);
    check("t1_done", n_done - b_done, 1); check("t1_err", err, 0); check("t1_busy", busy, 0);

    snap(); xfer(1'b1, 2'd0, 6'd7, 8'd0, 32'hDEAD_BEEF, 1'b1);
    check("t2_ack_once", n_ack - b_ack, 1); check("t2_wack", n_wack - b_wack, 1);
    check("t2_rv", n_rv - b_rv, 0);
    xfer(1'b0, 2'd0, 6'd7, 8'd0, '0, 1'b0);
    check("t2_readback", last_rd, 32'hDEAD_BEEF);

    snap(); xfer(1'b0, 2'd1, 6'd0, 8'd3, '0, 1'b0);
    check("t3_ads", n_ads - b_ads, 4); check("t3_cs2", n_cs2 - b_cs2, 4);
    check("t3_rv", n_rv - b_rv, 4);    check("t3_sum", rd_sum - b_sum, 6);
    check("t3_last", last_rd, 3);      check("t3_hk_cnt", hk_cnt, 4);

    stall = 1'b1;
    snap(); xfer(1'b0, 2'd0, 6'd5, 8'd2, '0, 1'b0);
    check("t4_wait_cycles", n_nrd - b_nrd, 16); check("t4_err", err, 1);
    check("t4_rv", n_rv - b_rv, 0); check("t4_done", n_done - b_done, 1);
    check("t4_ads", n_ads - b_ads, 1);
    stall = 1'b0;
    repeat (4) @(negedge clk);

    snap(); xfer(1'b0, 2'd3, 6'd1, 8'd0, '0, 1'b0);
    check("sp3_err", err, 1); check("sp3_ads", n_ads - b_ads, 0);
    check("sp3_done", n_done - b_done, 1); check("sp3_ack", n_ack - b_ack, 1);

    xfer(1'b0, 2'd2, 6'd3, 8'd0, '0, 1'b0);
    check("t5_err_clr", err, 0);
    xfer(1'b1, 2'd2, 6'd3, 8'd0, 32'h1234_5678, 1'b0);
    xfer(1'b0, 2'd2, 6'd3, 8'd0, '0, 1'b0);
    check("t5_lab_rb", last_rd, 32'h1234_5678);
    check("t5_contention", n_cont, 0); check("t5_stray_drive", n_bad, 0);

    stall = 1'b1;
    req_wr = 1'b1; req_space = 2'd0; req_addr = 6'd9; req_len = 8'd0; wdat = 32'hA5A5_0F0F;
    req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (req_ack) seen = 1'b1;
    end
    req = 1'b0;
    check("t6_ack", seen, 1);
    @(negedge clk);
    check("t6_in_wait_drive", dut.ld_oe_q, 1);
    snap();
    nrst = 1'b0;
    #1;
    check("t6_ld_oe", dut.ld_oe_q, 0); check("t6_nads", nads, 1); check("t6_ncs2", ncs2, 1);
    check("t6_ncs3", ncs3, 1); check("t6_nrd", nrd, 1); check("t6_wnr", wnr, 1);
    check("t6_busy", busy, 0);
    repeat (3) @(negedge clk);
    stall = 1'b0;
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_done", n_done - b_done, 0);
    xfer(1'b0, 2'd0, 6'd0, 8'd0, '0, 1'b0);
    check("t6_after_rst", last_rd, 32'h5355_5246); check("t6_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
